// File: rtl/csr_trap_unit.sv
// Supervisor CSR file and trap/mret sequencer for the MEM stage of the RV32 pipeline.
// Optional read-only cycle/instret counters are built when CSR_COUNTERS_EN is defined.
module csr_trap_unit #(
   parameter logic [31:0] TVEC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        valid_i,
   input  logic        int_signal_i,
   input  logic [7:0]  scause_i,
   input  logic        mret_i,
   input  logic        csrrs_i,
   input  logic [11:0] csr_addr_i,
   input  logic [31:0] csr_wdata_i,
   input  logic [31:0] pc_i,
   output logic [31:0] csr_rdata_o,
   output logic        flush_o,
   output logic        stall_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o
);

   localparam logic [11:0] ADDR_SSTATUS = 12'h100;
   localparam logic [11:0] ADDR_STVEC   = 12'h105;
   localparam logic [11:0] ADDR_SEPC    = 12'h141;
   localparam logic [11:0] ADDR_SCAUSE  = 12'h142;
`ifdef CSR_COUNTERS_EN
   localparam logic [11:0] ADDR_CYCLE   = 12'hC00;
   localparam logic [11:0] ADDR_INSTRET = 12'hC02;
`endif

   typedef enum logic [1:0] {IDLE, T_FLUSH, T_JUMP, R_JUMP} state_t;

   state_t      state_q;
   state_t      state_d;
   logic        sie_q;
   logic        spie_q;
   logic [31:0] stvec_q;
   logic [31:0] sepc_q;
   logic [7:0]  scause_q;

   logic accept;
   logic take_trap;
   logic take_mret;
   logic take_write;

   // Requests are only honoured in IDLE; priority is trap, then mret, then csrrs.
   assign accept     = (state_q == IDLE) && valid_i;
   assign take_trap  = accept && int_signal_i;
   assign take_mret  = accept && !int_signal_i && mret_i;
   assign take_write = accept && !int_signal_i && !mret_i && csrrs_i && (csr_wdata_i != 32'h0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (take_trap) begin
               state_d = T_FLUSH;
            end else if (take_mret) begin
               state_d = R_JUMP;
            end
         end
         T_FLUSH: state_d = T_JUMP;
         T_JUMP:  state_d = IDLE;
         R_JUMP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control outputs come only from registered state so the front end sees no input glitches.
   always_comb begin
      flush_o       = 1'b0;
      stall_o       = 1'b0;
      redirect_o    = 1'b0;
      redirect_pc_o = 32'h0;
      case (state_q)
         T_FLUSH: begin
            flush_o = 1'b1;
            stall_o = 1'b1;
         end
         T_JUMP: begin
            flush_o       = 1'b1;
            redirect_o    = 1'b1;
            redirect_pc_o = stvec_q & 32'hFFFF_FFFC;
         end
         R_JUMP: begin
            flush_o       = 1'b1;
            redirect_o    = 1'b1;
            redirect_pc_o = sepc_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sie_q    <= 1'b0;
         spie_q   <= 1'b0;
         stvec_q  <= TVEC_RESET;
         sepc_q   <= 32'h0;
         scause_q <= 8'h0;
      end else if (take_trap) begin
         sepc_q   <= pc_i & 32'hFFFF_FFFC;
         scause_q <= scause_i;
         spie_q   <= sie_q;
         sie_q    <= 1'b0;
      end else if (take_mret) begin
         sie_q    <= spie_q;
         spie_q   <= 1'b1;
      end else if (take_write) begin
         case (csr_addr_i)
            ADDR_SSTATUS: begin
               sie_q  <= sie_q | csr_wdata_i[1];
               spie_q <= spie_q | csr_wdata_i[5];
            end
            ADDR_STVEC:  stvec_q  <= stvec_q | csr_wdata_i;
            ADDR_SEPC:   sepc_q   <= (sepc_q | csr_wdata_i) & 32'hFFFF_FFFC;
            ADDR_SCAUSE: scause_q <= scause_q | csr_wdata_i[7:0];
            default: ;
         endcase
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [31:0] cycle_q;
   logic [31:0] instret_q;

   // Retired count includes every valid non-trapping instruction seen while IDLE; both wrap freely.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cycle_q   <= 32'h0;
         instret_q <= 32'h0;
      end else begin
         cycle_q <= cycle_q + 32'd1;
         if (accept && !int_signal_i) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end
`endif

   always_comb begin
      csr_rdata_o = 32'h0;
      if (csrrs_i) begin
         case (csr_addr_i)
            ADDR_SSTATUS: csr_rdata_o = {26'h0, spie_q, 3'b000, sie_q, 1'b0};
            ADDR_STVEC:   csr_rdata_o = stvec_q;
            ADDR_SEPC:    csr_rdata_o = sepc_q;
            ADDR_SCAUSE:  csr_rdata_o = {24'h0, scause_q};
`ifdef CSR_COUNTERS_EN
            ADDR_CYCLE:   csr_rdata_o = cycle_q;
            ADDR_INSTRET: csr_rdata_o = instret_q;
`endif
            default:      csr_rdata_o = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: a cycle-level model of the CSR/trap rules plus directed
// vectors with hand-computed values. CSR_COUNTERS_EN selects the counter checks.
module tb_csr_trap_unit;

   logic        clk;
   logic        rstn;
   logic        valid_i;
   logic        int_signal_i;
   logic [7:0]  scause_i;
   logic        mret_i;
   logic        csrrs_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] pc_i;
   logic [31:0] csr_rdata_o;
   logic        flush_o;
   logic        stall_o;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;

   int checks = 0;
   int errors = 0;

   csr_trap_unit #(.TVEC_RESET(32'h0000_0100)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .valid_i      (valid_i),
      .int_signal_i (int_signal_i),
      .scause_i     (scause_i),
      .mret_i       (mret_i),
      .csrrs_i      (csrrs_i),
      .csr_addr_i   (csr_addr_i),
      .csr_wdata_i  (csr_wdata_i),
      .pc_i         (pc_i),
      .csr_rdata_o  (csr_rdata_o),
      .flush_o      (flush_o),
      .stall_o      (stall_o),
      .redirect_o   (redirect_o),
      .redirect_pc_o(redirect_pc_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        flush;
      logic        stall;
      logic        redirect;
      logic [31:0] pc;
   } ctrl_t;

   // Model state: architectural CSR contents plus the list of control cycles still owed.
   ctrl_t       exp_q[$];
   logic        m_sie = 1'b0;
   logic        m_spie = 1'b0;
   logic [31:0] m_stvec = 32'h100;
   logic [31:0] m_sepc = 32'h0;
   logic [7:0]  m_scause = 8'h0;
   logic [31:0] m_cycle = 32'h0;
   logic [31:0] m_instret = 32'h0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic rd, input logic [11:0] addr);
      if (!rd) return 32'h0;
      case (addr)
         12'h100: return (m_sie ? 32'h2 : 32'h0) + (m_spie ? 32'h20 : 32'h0);
         12'h105: return m_stvec;
         12'h141: return m_sepc;
         12'h142: return {24'h0, m_scause};
`ifdef CSR_COUNTERS_EN
         12'hC00: return m_cycle;
         12'hC02: return m_instret;
`endif
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_sie = 1'b0;
      m_spie = 1'b0;
      m_stvec = 32'h100;
      m_sepc = 32'h0;
      m_scause = 8'h0;
      m_cycle = 32'h0;
      m_instret = 32'h0;
   endtask

   task automatic model_step();
      bit    busy;
      ctrl_t c;
      busy = (exp_q.size() != 0);
      if (busy) void'(exp_q.pop_front());
      m_cycle = m_cycle + 1;
      if (!busy && valid_i && !int_signal_i) m_instret = m_instret + 1;
      if (!busy && valid_i) begin
         if (int_signal_i) begin
            m_sepc   = {pc_i[31:2], 2'b00};
            m_scause = scause_i;
            m_spie   = m_sie;
            m_sie    = 1'b0;
            c = '{flush: 1'b1, stall: 1'b1, redirect: 1'b0, pc: 32'h0};
            exp_q.push_back(c);
            c = '{flush: 1'b1, stall: 1'b0, redirect: 1'b1, pc: {m_stvec[31:2], 2'b00}};
            exp_q.push_back(c);
         end else if (mret_i) begin
            m_sie  = m_spie;
            m_spie = 1'b1;
            c = '{flush: 1'b1, stall: 1'b0, redirect: 1'b1, pc: m_sepc};
            exp_q.push_back(c);
         end else if (csrrs_i && csr_wdata_i != 0) begin
            case (csr_addr_i)
               12'h100: begin
                  m_sie  = m_sie | csr_wdata_i[1];
                  m_spie = m_spie | csr_wdata_i[5];
               end
               12'h105: m_stvec = m_stvec | csr_wdata_i;
               12'h141: m_sepc = {m_sepc[31:2] | csr_wdata_i[31:2], 2'b00};
               12'h142: m_scause = m_scause | csr_wdata_i[7:0];
               default: ;
            endcase
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) model_reset();
         else model_step();
      end
   end

   // Every out-of-reset cycle the DUT outputs must match the model.
   initial begin
      ctrl_t e;
      forever begin
         @(negedge clk);
         if (rstn) begin
            e = (exp_q.size() != 0) ? exp_q[0] : '0;
            checkOutput("model flush", {31'h0, flush_o}, {31'h0, e.flush});
            checkOutput("model stall", {31'h0, stall_o}, {31'h0, e.stall});
            checkOutput("model redirect", {31'h0, redirect_o}, {31'h0, e.redirect});
            checkOutput("model redirect_pc", redirect_pc_o, e.pc);
            checkOutput("model csr_rdata", csr_rdata_o, model_read(csrrs_i, csr_addr_i));
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic t, input logic [7:0] c, input logic m,
                                input logic s, input logic [11:0] a, input logic [31:0] w,
                                input logic [31:0] p);
      @(posedge clk);
      #1;
      valid_i      = v;
      int_signal_i = t;
      scause_i     = c;
      mret_i       = m;
      csrrs_i      = s;
      csr_addr_i   = a;
      csr_wdata_i  = w;
      pc_i         = p;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0);
   endtask

   task automatic readCsr(input logic [11:0] a);
      applyStimulus(1'b1, 1'b0, 8'h0, 1'b0, 1'b1, a, 32'h0, 32'h0);
   endtask

   task automatic setCsr(input logic [11:0] a, input logic [31:0] w);
      applyStimulus(1'b1, 1'b0, 8'h0, 1'b0, 1'b1, a, w, 32'h0);
   endtask

   initial begin
      rstn = 1'b0;
      valid_i = 1'b0;
      int_signal_i = 1'b0;
      scause_i = 8'h0;
      mret_i = 1'b0;
      csrrs_i = 1'b0;
      csr_addr_i = 12'h0;
      csr_wdata_i = 32'h0;
      pc_i = 32'h0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset flush", {31'h0, flush_o}, 32'h0);
      checkOutput("reset stall", {31'h0, stall_o}, 32'h0);
      checkOutput("reset redirect", {31'h0, redirect_o}, 32'h0);
      checkOutput("reset redirect_pc", redirect_pc_o, 32'h0);
      #1 rstn = 1'b1;

      readCsr(12'h105); #1;
      checkOutput("stvec reset", csr_rdata_o, 32'h0000_0100);
      checkOutput("idle redirect", {31'h0, redirect_o}, 32'h0);

      setCsr(12'h100, 32'h2);
      readCsr(12'h100); #1;
      checkOutput("sstatus SIE set", csr_rdata_o, 32'h2);

      // ECALL at 0x40 with SIE=1
      applyStimulus(1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0000_0040);
      idleCycle(); #1;
      checkOutput("trap flush", {31'h0, flush_o}, 32'h1);
      checkOutput("trap stall", {31'h0, stall_o}, 32'h1);
      checkOutput("trap no early redirect", {31'h0, redirect_o}, 32'h0);
      idleCycle(); #1;
      checkOutput("trap redirect", {31'h0, redirect_o}, 32'h1);
      checkOutput("trap redirect_pc", redirect_pc_o, 32'h0000_0100);
      readCsr(12'h141); #1;
      checkOutput("sepc after ecall", csr_rdata_o, 32'h0000_0040);
      readCsr(12'h142); #1;
      checkOutput("scause after ecall", csr_rdata_o, 32'h8);
      readCsr(12'h100); #1;
      checkOutput("sstatus after ecall", csr_rdata_o, 32'h20);

      applyStimulus(1'b1, 1'b0, 8'h0, 1'b1, 1'b0, 12'h0, 32'h0, 32'h0);
      idleCycle(); #1;
      checkOutput("mret redirect", {31'h0, redirect_o}, 32'h1);
      checkOutput("mret redirect_pc", redirect_pc_o, 32'h0000_0040);
      readCsr(12'h100); #1;
      checkOutput("sstatus after mret", csr_rdata_o, 32'h22);

      // stvec write immediately followed by a trap that also carries mret/csrrs
      setCsr(12'h105, 32'h0000_0203);
      applyStimulus(1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 12'h141, 32'hFFFF_FFFF, 32'h0000_0088);
      applyStimulus(1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 12'h105, 32'hFFFF_FFFF, 32'h0000_0099); #1;
      checkOutput("busy flush", {31'h0, flush_o}, 32'h1);
      checkOutput("busy stvec read", csr_rdata_o, 32'h0000_0303);
      applyStimulus(1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 12'h105, 32'hFFFF_FFFF, 32'h0000_0099); #1;
      checkOutput("new stvec redirect_pc", redirect_pc_o, 32'h0000_0300);
      idleCycle(); #1;
      checkOutput("single redirect", {31'h0, redirect_o}, 32'h0);
      readCsr(12'h141); #1;
      checkOutput("sepc unwritten", csr_rdata_o, 32'h0000_0088);
      readCsr(12'h105); #1;
      checkOutput("stvec unwritten", csr_rdata_o, 32'h0000_0303);
      readCsr(12'h142); #1;
      checkOutput("scause illegal", csr_rdata_o, 32'h2);
      readCsr(12'h100); #1;
      checkOutput("sstatus second trap", csr_rdata_o, 32'h20);

      setCsr(12'h141, 32'h7);
      readCsr(12'h141); #1;
      checkOutput("sepc low bits", csr_rdata_o, 32'h0000_008C);
      setCsr(12'h142, 32'hFFFF_0010);
      readCsr(12'h142); #1;
      checkOutput("scause set", csr_rdata_o, 32'h12);
      setCsr(12'h123, 32'hFFFF_FFFF);
      readCsr(12'h123); #1;
      checkOutput("unmapped read", csr_rdata_o, 32'h0);
      applyStimulus(1'b0, 1'b0, 8'h0, 1'b0, 1'b1, 12'h105, 32'hFFFF_FFFF, 32'h0);
      readCsr(12'h105); #1;
      checkOutput("invalid csrrs ignored", csr_rdata_o, 32'h0000_0303);
      applyStimulus(1'b1, 1'b0, 8'h0, 1'b0, 1'b0, 12'h105, 32'h0, 32'h0); #1;
      checkOutput("rdata without csrrs", csr_rdata_o, 32'h0);
`ifndef CSR_COUNTERS_EN
      readCsr(12'hC00); #1;
      checkOutput("cycle absent", csr_rdata_o, 32'h0);
`endif

      // reset pulse during T_FLUSH
      applyStimulus(1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 12'h0, 32'h0, 32'h0000_0050);
      idleCycle(); #1;
      rstn = 1'b0;
      #1;
      checkOutput("async reset flush", {31'h0, flush_o}, 32'h0);
      checkOutput("async reset stall", {31'h0, stall_o}, 32'h0);
      repeat (2) begin
         idleCycle(); #1;
         checkOutput("reset no redirect", {31'h0, redirect_o}, 32'h0);
      end
      rstn = 1'b1;
      idleCycle(); #1;
      checkOutput("post reset no redirect", {31'h0, redirect_o}, 32'h0);
      readCsr(12'h141); #1;
      checkOutput("sepc after reset", csr_rdata_o, 32'h0);
      readCsr(12'h105); #1;
      checkOutput("stvec after reset", csr_rdata_o, 32'h0000_0100);

`ifdef CSR_COUNTERS_EN
      readCsr(12'hC00);
      force dut.cycle_q = 32'hFFFF_FFFF;
      m_cycle = 32'hFFFF_FFFF;
      #6 release dut.cycle_q;
      @(posedge clk); #2;
      checkOutput("cycle wrap", csr_rdata_o, 32'h0);
      readCsr(12'hC02); #1;
      checkOutput("instret value", csr_rdata_o, m_instret);
`endif

      idleCycle();
      idleCycle();
      @(posedge clk); #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Supervisor CSR and trap sequencer for the pipelined RV32 core. It sits directly downstream of the control decoder and consumes its `INT_Signal`, `SCAUSE`, `MRET` and `CSRRS` outputs once they reach the MEM stage. It holds `sstatus`/`stvec`/`sepc`/`scause`, and supplies CSR read data for the `WDSel` CSR path. It also sequences pipeline flush and PC redirect on trap entry and `mret`.

## Interface
- `TVEC_RESET`, default `32'h0000_0000`: reset value of `stvec`.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  MEM-stage instruction is valid (not bubbled or flushed).
- `int_signal_i`  in  1  trap request from the decoder, pipelined to MEM.
- `scause_i`  in  8  cause code (ECALL = 8'h08, illegal = 8'h02).
- `mret_i`  in  1  MEM-stage instruction is `mret`.
- `csrrs_i`  in  1  MEM-stage instruction is `csrrs`.
- `csr_addr_i`  in  12  CSR address (instr[31:20]).
- `csr_wdata_i`  in  32  rs1 value (set mask).
- `pc_i`  in  32  PC of the MEM-stage instruction.
- `csr_rdata_o`  out  32  old value of the addressed CSR (combinational).
- `flush_o`  out  1  kill IF/ID/EX contents.
- `stall_o`  out  1  hold PC and IF/ID.
- `redirect_o`  out  1  load PC from `redirect_pc_o` this cycle.
- `redirect_pc_o`  out  32  redirect target.

## Operation
- CSR map:
  - `sstatus` 0x100: bit1 SIE, bit5 SPIE; other bits read 0.
  - `stvec` 0x105: 32-bit.
  - `sepc` 0x141: bits[1:0] always 0.
  - `scause` 0x142: {24'b0, cause}.
  - Unmapped addresses read 0; writes to them are ignored.
- FSM states: IDLE, T_FLUSH, T_JUMP, R_JUMP.
- In IDLE, when `valid_i` is high, the first true item below wins:
  1. `int_signal_i` (trap entry):
     - `sepc <= {pc_i[31:2],2'b00}`, `scause <= scause_i`.
     - SPIE <= SIE, SIE <= 0.
     - Next state T_FLUSH. Any simultaneous `mret_i`/`csrrs_i` is ignored.
  2. `mret_i`: SIE <= SPIE, SPIE <= 1; next state R_JUMP.
  3. `csrrs_i`:
     - `csr_rdata_o` = old value.
     - If `csr_wdata_i != 0`, the writable CSR gets old | `csr_wdata_i`, with `sepc` bits[1:0] still forced 0.
     - Stay in IDLE.
- T_FLUSH: `flush_o`=1, `stall_o`=1; next state T_JUMP.
- T_JUMP: `flush_o`=1, `redirect_o`=1, `redirect_pc_o`={stvec[31:2],2'b00}; next state IDLE.
- R_JUMP: `flush_o`=1, `redirect_o`=1, `redirect_pc_o`=sepc; next state IDLE.
- Outside IDLE, all request inputs are ignored (no CSR writes, no new trap).
- `csr_rdata_o` decodes `csr_addr_i` in every state; it is 0 unless `csrrs_i` is high.
- The front end honours `redirect_o` regardless of `stall_o`.

## Timing
- Reset values:
  - All CSRs 0 except `stvec`=`TVEC_RESET`.
  - FSM state IDLE.
  - `flush_o`, `stall_o`, `redirect_o` = 0; `redirect_pc_o` = 0.
- Trap captured at edge N: CSRs updated at N; T_FLUSH during cycle N→N+1; T_JUMP (redirect) during N+1→N+2; IDLE again from N+2.
- `mret` captured at edge N: redirect asserted during N→N+1; IDLE from N+1.
- CSR read: zero-latency combinational. The write becomes visible to the next instruction (cycle after the edge).
- Trap in the same cycle as a prior `csrrs` write to `stvec`: the redirect uses the new `stvec`.
- Control outputs are decoded from registered state only (glitch-free, no input-to-output paths). `csr_rdata_o` is the one combinational output.
- `rstn` low mid-sequence: FSM returns to IDLE immediately and all outputs drop to 0 asynchronously; no redirect is issued.

## Configuration
- `CSR_COUNTERS_EN` defined:
  - Adds read-only `cycle` (0xC00) and `instret` (0xC02), both 32-bit, reset 0.
  - `cycle` increments every clock.
  - `instret` increments on edges where state is IDLE, `valid_i` is high and `int_signal_i` is low.
  - Both wrap from 32'hFFFF_FFFF to 0.
  - `csrrs` set writes to these addresses are ignored.
- Undefined: no counter registers; 0xC00/0xC02 read 0.

## Test plan
- Reset with `TVEC_RESET`=32'h0000_0100, read 0x105 via `csrrs` with wdata 0 -> `csr_rdata_o`=32'h0000_0100; flush/stall/redirect all 0.
- ECALL at `pc_i`=32'h0000_0040 with SIE=1 -> next cycle `flush_o`=`stall_o`=1; following cycle `redirect_o`=1, pc 32'h0000_0100. After that, `sepc` reads 32'h0000_0040, `scause` 32'h8, `sstatus` 32'h20.
- `mret` after the above -> one cycle of `redirect_o`=1 with pc 32'h0000_0040; `sstatus` reads 32'h22.
- Trap with `mret_i`=`csrrs_i`=1 in the same cycle, then new requests held high during T_FLUSH -> only trap effects occur; no CSR write; single redirect.
- `rstn` pulsed low during T_FLUSH -> `redirect_o` never asserts; FSM IDLE; `sepc` reads 0.
- With `CSR_COUNTERS_EN`, preload `cycle` to 32'hFFFF_FFFF via force -> after one clock, read 0xC00 = 0. Without the macro, 0xC00 reads 0.
